// File: rtl/float_normalizer_if.sv
// Handshake bundle for float_normalizer: operand in (valid/ready), packed single out (valid/ready).
// slave = the normalizer's view, master = the producer/consumer side.
interface float_normalizer_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SIG_W = MAN_W + 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [SIG_W-1:0]       in_sig;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_float;
  logic                   out_zero;
  logic                   out_overflow;
  logic                   out_underflow;

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_float, out_zero, out_overflow, out_underflow
  );

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_float, out_zero, out_overflow, out_underflow
  );
endinterface

// File: rtl/float_normalizer.sv
// Normalize-and-pack: one shift per cycle until the hidden bit lands, 1..24 cycles after accept.
// One operand in flight; result held in DONE until out_ready, no new accept meanwhile.
module float_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SIG_W = MAN_W + 2
) (
  input  logic                clk,
  input  logic                reset,
  float_normalizer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int            FLT_W   = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t             state, state_n;
  logic               sign_q, sign_n;
  logic [EXP_W-1:0]   exp_q, exp_n;
  logic [SIG_W-1:0]   sig_q, sig_n;
  logic               bypass_q, bypass_n;
  logic [FLT_W-1:0]   float_q, float_n;
  logic               zero_q, zero_n;
  logic               ovf_q, ovf_n;
  logic               unf_q, unf_n;
  logic [EXP_W-1:0]   exp_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      bypass_q <= 1'b0;
      float_q  <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      sign_q   <= sign_n;
      exp_q    <= exp_n;
      sig_q    <= sig_n;
      bypass_q <= bypass_n;
      float_q  <= float_n;
      zero_q   <= zero_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
    end
  end

  always_comb begin
    state_n  = state;
    sign_n   = sign_q;
    exp_n    = exp_q;
    sig_n    = sig_q;
    bypass_n = bypass_q;
    float_n  = float_q;
    zero_n   = zero_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    exp_inc  = exp_q + EXP_ONE;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_n   = bus.in_sign;
          exp_n    = bus.in_exp;
          sig_n    = bus.in_sig;
          // Infinite input exponent is resolved in the first SHIFT cycle, ahead of the zero check.
          bypass_n = (bus.in_exp == EXP_MAX);
          float_n  = '0;
          zero_n   = 1'b0;
          ovf_n    = 1'b0;
          unf_n    = 1'b0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (bypass_q) begin
          float_n = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
          ovf_n   = 1'b1;
          state_n = DONE;
        end else if (sig_q == '0) begin
          float_n = '0;
          zero_n  = 1'b1;
          state_n = DONE;
        end else if (sig_q[SIG_W-1]) begin
          sig_n = sig_q >> 1;
          exp_n = exp_inc;
          if (exp_inc == EXP_MAX) begin
            float_n = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            ovf_n   = 1'b1;
            state_n = DONE;
          end
        end else if (sig_q[MAN_W]) begin
          float_n = {sign_q, exp_q, sig_q[MAN_W-1:0]};
          state_n = DONE;
        end else begin
          sig_n = sig_q << 1;
          exp_n = exp_q - EXP_ONE;
          // exp==0 would wrap on decrement, so it underflows just like exp==1.
          if (exp_q <= EXP_ONE) begin
            float_n = '0;
            unf_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.out_float     = float_q;
  assign bus.out_zero      = zero_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;

endmodule

// File: tb/tb_float_normalizer.sv
// Bench for float_normalizer: directed cases pinned to literals, then random operands vs a value-level model.
module tb_float_normalizer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  float_normalizer_if bus ();
  float_normalizer dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] f;
    logic [2:0]  flg;   // {zero, overflow, underflow}
    int          lat;
  } res_t;

  res_t exp_r;
  logic exp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, then decide the outcome from exponent room.
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [24:0] sig);
    res_t r;
    int p, d, k;
    logic [24:0] sh;
    r.f = 32'h0; r.flg = 3'b000; r.lat = 1;
    p = 0;
    if (e == 8'hFF) begin
      r.f = {s, 8'hFF, 23'h0}; r.flg = 3'b010; return r;
    end
    if (sig == 25'h0) begin
      r.flg = 3'b100; return r;
    end
    for (int i = 0; i < 25; i++) if (sig[i]) p = i;
    if (p == 24) begin
      if (int'(e) + 1 == 255) begin
        r.f = {s, 8'hFF, 23'h0}; r.flg = 3'b010; r.lat = 1;
      end else begin
        r.f = {s, e + 8'd1, sig[23:1]}; r.lat = 2;
      end
      return r;
    end
    d = 23 - p;
    k = (e == 8'h0) ? 1 : int'(e);
    if (d > 0 && k <= d) begin
      r.flg = 3'b001; r.lat = k; return r;
    end
    sh = sig << d;
    r.f = {s, e - 8'(d), sh[22:0]};
    r.lat = d + 1;
    return r;
  endfunction

  // Every cycle the result is presented it must match the model and hold off new input.
  always @(negedge clk) begin
    if (exp_on && !reset && bus.out_valid) begin
      check("out_float", bus.out_float, exp_r.f);
      check("flags", {29'h0, bus.out_zero, bus.out_overflow, bus.out_underflow}, {29'h0, exp_r.flg});
      check("in_ready_in_done", {31'h0, bus.in_ready}, 32'h0);
    end
  end

  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] sig, input int hold);
    int lat;
    exp_r  = model(s, e, sig);
    exp_on = 1'b1;
    @(negedge clk);
    check("in_ready_idle", {31'h0, bus.in_ready}, 32'h1);
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e; bus.in_sig = sig;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("out_valid_timeout", {31'h0, bus.out_valid}, 32'h1);
    check("latency", lat, exp_r.lat);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_on = 1'b0;
    check("out_valid_drop", {31'h0, bus.out_valid}, 32'h0);
    check("in_ready_back", {31'h0, bus.in_ready}, 32'h1);
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] sig;
    logic [31:0] f;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  vec_t dir [7];

  initial begin
    res_t m;
    dir[0] = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 3'b000, 1};
    dir[1] = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 3'b000, 2};
    dir[2] = '{1'b1, 8'h7F, 25'h0000001, 32'hB4000000, 3'b000, 24};
    dir[3] = '{1'b1, 8'h55, 25'h0000000, 32'h00000000, 3'b100, 1};
    dir[4] = '{1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 3'b010, 1};
    dir[5] = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b010, 1};
    dir[6] = '{1'b0, 8'h02, 25'h0200000, 32'h00000000, 3'b001, 2};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = 8'h0; bus.in_sig = 25'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_float", bus.out_float, 32'h0);
    check("rst_flags", {29'h0, bus.out_zero, bus.out_overflow, bus.out_underflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (dir[i]) begin
      m = model(dir[i].s, dir[i].e, dir[i].sig);
      check("model_float", m.f, dir[i].f);
      check("model_flags", {29'h0, m.flg}, {29'h0, dir[i].flg});
      check("model_lat", m.lat, dir[i].lat);
      run_op(dir[i].s, dir[i].e, dir[i].sig, (i == 0) ? 5 : 1);
    end

    // Abort mid-shift of the long left-shift case, then prove the block is reusable.
    exp_on = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_exp = 8'h7F; bus.in_sig = 25'h0000001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("abort_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("abort_out_float", bus.out_float, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 8'h7F, 25'h0800000, 0);

    for (int n = 0; n < 150; n++) begin
      logic        s;
      logic [7:0]  e;
      logic [24:0] sig;
      logic [24:0] one;
      int          p;
      int          sel;
      one = 25'h1;
      s   = 1'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'hFF;
        3: e = 8'hFE;
        default: e = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        sig = 25'h0;
      end else begin
        p   = $urandom_range(0, 24);
        sig = (one << p) | (25'($urandom) & ((one << p) - one));
      end
      run_op(s, e, sig, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
